// File: rtl/w_writeback_grf.sv
// w_writeback_grf: write-back stage, 32x32 register file with W->D bypass,
// and a retired-instruction counter.
//
// Ports:
//   clk, reset        clock; async active-high reset (clears GRF, counter)
//   IR_W, PC8_W       instruction / PC+8 in W (IR_W == 0 is a bubble)
//   A3_W, AO_W, DR_W  destination index, ALU result/address, raw load word
//   RES_W             result source: 1 ALU, 2 DM, 3 PC8, others none
//   A1, A2 -> RD1/RD2 D-stage read ports (combinational, bypassed)
//   WD_W, WE_W        selected write-back value and effective write enable
//   retired           count of non-bubble instructions retired
//
// Build option: define GRF_DISPLAY_EN to log every register write.

module w_writeback_grf #(
    parameter int NREG  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      IR_W,
    input  logic [31:0]      PC8_W,
    input  logic [4:0]       A3_W,
    input  logic [31:0]      AO_W,
    input  logic [31:0]      DR_W,
    input  logic [2:0]       RES_W,
    input  logic [4:0]       A1,
    input  logic [4:0]       A2,
    output logic [31:0]      RD1,
    output logic [31:0]      RD2,
    output logic [31:0]      WD_W,
    output logic             WE_W,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] RES_ALU = 3'd1;
    localparam logic [2:0] RES_DM  = 3'd2;
    localparam logic [2:0] RES_PC8 = 3'd3;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;

    logic [31:0]      grf [NREG];
    logic [31:0]      ld_ext;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [CNT_W-1:0] retired_q;

    // Little-endian lane pick; halves use AO_W[1] only, so an odd
    // address is silently treated as the enclosing aligned half.
    assign ld_byte = DR_W[{AO_W[1:0], 3'b000} +: 8];
    assign ld_half = DR_W[{AO_W[1], 4'b0000} +: 16];

    always_comb begin
        ld_ext = DR_W;
        case (IR_W[31:26])
            OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_ext = {24'b0, ld_byte};
            OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_ext = {16'b0, ld_half};
            OP_LW:   ld_ext = DR_W;
            default: ld_ext = DR_W;
        endcase
    end

    always_comb begin
        WD_W = 32'b0;
        unique case (RES_W)
            RES_ALU: WD_W = AO_W;
            RES_DM:  WD_W = ld_ext;
            RES_PC8: WD_W = PC8_W;
            default: WD_W = 32'b0;
        endcase
    end

    // $0 is never written, so WE_W already excludes A3_W == 0.
    assign WE_W = (RES_W == RES_ALU || RES_W == RES_DM || RES_W == RES_PC8)
                  && (A3_W != 5'd0);

    always_comb begin
        RD1 = grf[A1];
        if (A1 == 5'd0)
            RD1 = 32'b0;
        else if (WE_W && A1 == A3_W)
            RD1 = WD_W;
    end

    always_comb begin
        RD2 = grf[A2];
        if (A2 == 5'd0)
            RD2 = 32'b0;
        else if (WE_W && A2 == A3_W)
            RD2 = WD_W;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                grf[i] <= 32'b0;
        end else if (WE_W) begin
            grf[A3_W] <= WD_W;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            retired_q <= '0;
        else if (IR_W != 32'b0)
            retired_q <= retired_q + CNT_W'(1);
    end

    assign retired = retired_q;

`ifdef GRF_DISPLAY_EN
    always @(posedge clk) begin
        if (WE_W && !reset)
            $display("@%h: $%d <= %h", PC8_W - 32'd8, A3_W, WD_W);
    end
`else
`endif

endmodule

// File: tb/tb_w_writeback_grf.sv
// tb_w_writeback_grf: scoreboard bench for w_writeback_grf.
// A second instance with a 4-bit counter exercises counter wrap.

module tb_w_writeback_grf;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] IR_W = '0, PC8_W = '0, AO_W = '0, DR_W = '0;
    logic [4:0]  A3_W = '0, A1 = '0, A2 = '0;
    logic [2:0]  RES_W = '0;
    logic [31:0] RD1, RD2, WD_W, retired;
    logic        WE_W;
    logic [31:0] RD1_b, RD2_b, WD_W_b;
    logic        WE_W_b;
    logic [3:0]  retired4;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_t;

    sb_t         sb[$];
    logic [31:0] mgrf [32];
    logic [31:0] mret;
    int          n_chk = 0;
    int          n_fail = 0;

    localparam logic [31:0] DRV = 32'h80FF7F01;

    always #5 clk = ~clk;

    w_writeback_grf #(.NREG(32), .CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .IR_W(IR_W), .PC8_W(PC8_W),
        .A3_W(A3_W), .AO_W(AO_W), .DR_W(DR_W), .RES_W(RES_W),
        .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .WD_W(WD_W), .WE_W(WE_W), .retired(retired)
    );

    w_writeback_grf #(.NREG(32), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .IR_W(IR_W), .PC8_W(PC8_W),
        .A3_W(A3_W), .AO_W(AO_W), .DR_W(DR_W), .RES_W(RES_W),
        .A1(A1), .A2(A2), .RD1(RD1_b), .RD2(RD2_b),
        .WD_W(WD_W_b), .WE_W(WE_W_b), .retired(retired4)
    );

    task automatic check_eq(string tag, logic [31:0] obs,
                            logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic push(string tag, logic [31:0] v);
        sb_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(logic [31:0] obs);
        sb_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_empty: got %h want entry", obs);
        end else begin
            e = sb.pop_front();
            check_eq(e.tag, obs, e.val);
        end
    endtask

    function automatic logic [31:0] mread(logic [4:0] a, logic we,
                                          logic [4:0] a3,
                                          logic [31:0] wd);
        if (a == 5'd0) return 32'b0;
        if (we && a == a3) return wd;
        return mgrf[a];
    endfunction

    // Called just after a negedge; returns on the following negedge.
    task automatic step(string nm, logic [31:0] ir, logic [31:0] pc8,
                        logic [4:0] a3, logic [31:0] ao,
                        logic [31:0] dr, logic [2:0] res,
                        logic [4:0] a1, logic [4:0] a2,
                        logic [31:0] exp_wd);
        logic we;
        IR_W = ir; PC8_W = pc8; A3_W = a3; AO_W = ao;
        DR_W = dr; RES_W = res; A1 = a1; A2 = a2;
        we = (res >= 3'd1 && res <= 3'd3 && a3 != 5'd0);
        push({nm, ".we"}, {31'b0, we});
        push({nm, ".wd"}, exp_wd);
        push({nm, ".rd1"}, mread(a1, we, a3, exp_wd));
        push({nm, ".rd2"}, mread(a2, we, a3, exp_wd));
        #2;
        pop_chk({31'b0, WE_W});
        pop_chk(WD_W);
        pop_chk(RD1);
        pop_chk(RD2);
        @(posedge clk);
        if (!reset) begin
            if (we) mgrf[a3] = exp_wd;
            if (ir != 32'b0) mret = mret + 32'd1;
        end
        push({nm, ".ret"}, mret);
        push({nm, ".ret4"}, {28'b0, mret[3:0]});
        #1;
        pop_chk(retired);
        pop_chk({28'b0, retired4});
        @(negedge clk);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mgrf[i] = 32'b0;
        mret = 32'b0;
    endtask

    initial begin
        model_clear();
        A1 = 5'd5;
        A2 = 5'd31;
        @(negedge clk);
        @(negedge clk);
        push("rst.ret", 32'b0);
        push("rst.rd1", 32'b0);
        push("rst.rd2", 32'b0);
        pop_chk(retired);
        pop_chk(RD1);
        pop_chk(RD2);
        reset = 1'b0;

        step("alu", 32'h00A52820, 32'h3008, 5'd5, 32'h1234, 32'h0,
             3'd1, 5'd5, 5'd0, 32'h1234);
        step("rd5", 32'h0, 32'h0, 5'd0, 32'h0, 32'h0,
             3'd0, 5'd5, 5'd5, 32'h0);

        step("lb3", 32'h80000000, 32'h10, 5'd6, 32'h10000003, DRV,
             3'd2, 5'd0, 5'd6, 32'hFFFFFF80);
        step("lbu3", 32'h90000000, 32'h14, 5'd7, 32'h10000003, DRV,
             3'd2, 5'd6, 5'd7, 32'h00000080);
        step("lh0", 32'h84000000, 32'h18, 5'd8, 32'h10000000, DRV,
             3'd2, 5'd8, 5'd7, 32'h00007F01);
        step("lhu2", 32'h94000000, 32'h1C, 5'd9, 32'h10000002, DRV,
             3'd2, 5'd8, 5'd9, 32'h000080FF);
        step("lb1", 32'h80000000, 32'h20, 5'd10, 32'h10000001, DRV,
             3'd2, 5'd10, 5'd9, 32'h0000007F);
        step("lb2", 32'h80000000, 32'h24, 5'd11, 32'h10000002, DRV,
             3'd2, 5'd11, 5'd10, 32'hFFFFFFFF);
        step("lh3", 32'h84000000, 32'h28, 5'd12, 32'h10000003, DRV,
             3'd2, 5'd12, 5'd11, 32'hFFFF80FF);
        step("lhu1", 32'h94000000, 32'h2C, 5'd13, 32'h10000001, DRV,
             3'd2, 5'd13, 5'd12, 32'h00007F01);
        step("lw", 32'h8C000000, 32'h30, 5'd14, 32'h10000002, DRV,
             3'd2, 5'd14, 5'd13, DRV);
        step("ldoth", 32'h00000001, 32'h34, 5'd15, 32'h10000003, DRV,
             3'd2, 5'd6, 5'd15, DRV);

        step("jal", 32'h0C000C00, 32'h00003008, 5'd31, 32'h0, 32'h0,
             3'd3, 5'd31, 5'd5, 32'h00003008);
        step("zero", 32'h2000DEAD, 32'h40, 5'd0, 32'hDEAD, 32'h0,
             3'd1, 5'd0, 5'd31, 32'hDEAD);
        step("rd0", 32'h0, 32'h0, 5'd0, 32'h0, 32'h0,
             3'd0, 5'd0, 5'd9, 32'h0);
        step("res4", 32'h00000001, 32'h44, 5'd10, 32'h5555, 32'h0,
             3'd4, 5'd10, 5'd14, 32'h0);
        step("res7", 32'h00000001, 32'h48, 5'd11, 32'h5555, 32'h0,
             3'd7, 5'd11, 5'd10, 32'h0);

        // Async reset between edges while grf[5] holds 0x1234.
        IR_W = 32'h0; RES_W = 3'd0; A3_W = 5'd0; A1 = 5'd5; A2 = 5'd0;
        #1;
        push("pre.rd1", mgrf[5]);
        pop_chk(RD1);
        reset = 1'b1;
        #1;
        model_clear();
        push("arst.rd1", 32'b0);
        push("arst.ret", 32'b0);
        push("arst.ret4", 32'b0);
        pop_chk(RD1);
        pop_chk(retired);
        pop_chk({28'b0, retired4});
        @(negedge clk);
        step("rstwr", 32'h00000001, 32'h50, 5'd12, 32'h7777, 32'h0,
             3'd1, 5'd5, 5'd12, 32'h7777);
        reset = 1'b0;
        step("drop", 32'h0, 32'h0, 5'd0, 32'h0, 32'h0,
             3'd0, 5'd12, 5'd5, 32'h0);

        step("c1", 32'h00000001, 32'h60, 5'd1, 32'h11, 32'h0,
             3'd1, 5'd1, 5'd2, 32'h11);
        step("cb1", 32'h0, 32'h0, 5'd0, 32'h0, 32'h0,
             3'd0, 5'd1, 5'd0, 32'h0);
        step("c2", 32'h00000002, 32'h64, 5'd2, 32'h22, 32'h0,
             3'd1, 5'd1, 5'd2, 32'h22);
        step("cb2", 32'h0, 32'h0, 5'd0, 32'h0, 32'h0,
             3'd0, 5'd2, 5'd1, 32'h0);
        step("c3", 32'h00000003, 32'h68, 5'd3, 32'h33, 32'h0,
             3'd1, 5'd3, 5'd2, 32'h33);
        step("sw", 32'hAC000000, 32'h6C, 5'd4, 32'h44, 32'h0,
             3'd0, 5'd4, 5'd3, 32'h0);
        push("cnt4", 32'd4);
        pop_chk(retired);

        for (int i = 0; i < 12; i++)
            step("fill", 32'hAC000000 + i, 32'h70, 5'd0, 32'h0, 32'h0,
                 3'd0, 5'(i), 5'(31 - i), 32'h0);
        push("wrap4", 32'd0);
        push("cnt16", 32'd16);
        pop_chk({28'b0, retired4});
        pop_chk(retired);

        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_left: got %0d want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
